// File: rtl/pattern_tx_serializer.sv
// Frame serializer: SYNC_PATTERN preamble, payload MSB-first, then GAP_CYCLES idle bits.
// Define PATTERN_TX_PARITY_EN to append an even-parity bit after the payload.
module pattern_tx_serializer #(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = 5,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 5'b11010,
    parameter int                GAP_CYCLES   = 2,
    parameter logic              IDLE_BIT     = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              stream_out,
    output logic              sync_active,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_MAX_A = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CNT_MAX_B = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_B > 1) ? CNT_MAX_B : 1;
    localparam int CNT_W     = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DATA_PEN  = CNT_W'((DATA_W > 1) ? DATA_W - 2 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef PATTERN_TX_PARITY_EN
    localparam bit HAS_PARITY = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PARITY, S_GAP} state_t;
`else
    localparam bit HAS_PARITY = 1'b0;
    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_t;
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  shreg;
    logic [SYNC_W-1:0]  sync_sh;
`ifdef PATTERN_TX_PARITY_EN
    logic               par;
`endif

    assign data_ready = (state == S_IDLE) && !rst;

    // Outputs are registered one cycle ahead: each branch loads the bit that
    // the next state shows on its first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            shreg       <= '0;
            sync_sh     <= '0;
            stream_out  <= IDLE_BIT;
            sync_active <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    stream_out <= IDLE_BIT;
                    if (data_valid) begin
                        state       <= S_SYNC;
                        cnt         <= '0;
                        shreg       <= data_in;
                        sync_sh     <= SYNC_PATTERN << 1;
                        stream_out  <= SYNC_PATTERN[SYNC_W-1];
                        sync_active <= 1'b1;
                        busy        <= 1'b1;
`ifdef PATTERN_TX_PARITY_EN
                        par         <= ^data_in;
`endif
                    end
                end
                S_SYNC: begin
                    if (cnt == SYNC_LAST) begin
                        state       <= S_DATA;
                        cnt         <= '0;
                        stream_out  <= shreg[DATA_W-1];
                        shreg       <= shreg << 1;
                        sync_active <= 1'b0;
                        frame_done  <= (DATA_W == 1) && !HAS_PARITY;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        stream_out <= sync_sh[SYNC_W-1];
                        sync_sh    <= sync_sh << 1;
                    end
                end
                S_DATA: begin
                    if (cnt == DATA_LAST) begin
                        cnt <= '0;
`ifdef PATTERN_TX_PARITY_EN
                        state      <= S_PARITY;
                        stream_out <= par;
                        frame_done <= 1'b1;
`else
                        stream_out <= IDLE_BIT;
                        if (GAP_CYCLES > 0) begin
                            state <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
`endif
                    end else begin
                        cnt        <= cnt + 1'b1;
                        stream_out <= shreg[DATA_W-1];
                        shreg      <= shreg << 1;
                        frame_done <= !HAS_PARITY && (cnt == DATA_PEN);
                    end
                end
`ifdef PATTERN_TX_PARITY_EN
                S_PARITY: begin
                    cnt        <= '0;
                    stream_out <= IDLE_BIT;
                    if (GAP_CYCLES > 0) begin
                        state <= S_GAP;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                S_GAP: begin
                    stream_out <= IDLE_BIT;
                    if (cnt == GAP_LAST) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    cnt         <= '0;
                    stream_out  <= IDLE_BIT;
                    sync_active <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_tx_serializer.sv
// Directed bench for pattern_tx_serializer: table of frames plus hand-written
// back-to-back, mid-frame reset and loopback-detector sequences.
module tb_pattern_tx_serializer;

`ifdef PATTERN_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = 13 + PAR;      // frame bits on the line
    localparam int SP = 16 + PAR;      // frame start spacing

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready, stream_out, sync_active, busy, frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    pattern_tx_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .stream_out (stream_out),
        .sync_active(sync_active),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic [12:0] bits;
        logic        par;
        bit          det;
        string       nm;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Called at a negedge with the block idle; returns at the negedge where
    // data_ready is high again.
    task automatic send_frame(input vec_t v);
        logic [31:0] s_v, sy_v, dn_v, fi_v, exp_s;
        logic [3:0]  hist;
        logic        bad;
        check({v.nm, " ready_before"}, {31'b0, data_ready}, 32'd1);
        data_in    = v.d;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        s_v = '0; sy_v = '0; dn_v = '0; fi_v = '0; hist = '0;
        for (int i = 0; i < FL; i++) begin
            data_in = 8'($urandom);
            s_v  = {s_v[30:0], stream_out};
            sy_v = {sy_v[30:0], sync_active};
            dn_v = {dn_v[30:0], frame_done};
            fi_v = {fi_v[30:0], ({hist, stream_out} == 5'b11010)};
            hist = {hist[2:0], stream_out};
            if (i < FL - 1) @(negedge clk);
        end
        exp_s = (PAR == 1) ? {18'b0, v.bits, v.par} : {19'b0, v.bits};
        check({v.nm, " stream"}, s_v, exp_s);
        check({v.nm, " sync_active"}, sy_v, 32'h1F << (FL - 5));
        check({v.nm, " frame_done"}, dn_v, 32'd1);
        if (v.det) check({v.nm, " detector"}, fi_v, 32'd1 << (FL - 5));
        bad = 1'b0;
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            bad |= stream_out || !busy || data_ready || frame_done || sync_active;
        end
        check({v.nm, " gap"}, {31'b0, bad}, 32'd0);
        @(negedge clk);
        check({v.nm, " ready_after"}, {29'b0, data_ready, busy, stream_out}, 32'b100);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (data_ready && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, " idle_timeout"}, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        bad, seen;
        logic [31:0] s1, s2;
        int          rdy_cnt, rdy_at;
        vec_t        v81;

        tbl[0] = '{8'hA5, 13'b11010_10100101, 1'b0, 1'b0, "A5"};
        tbl[1] = '{8'h00, 13'b11010_00000000, 1'b0, 1'b1, "00a"};
        tbl[2] = '{8'h5A, 13'b11010_01011010, 1'b0, 1'b0, "5A"};
        tbl[3] = '{8'hC3, 13'b11010_11000011, 1'b0, 1'b0, "C3"};
        tbl[4] = '{8'h01, 13'b11010_00000001, 1'b1, 1'b0, "01"};
        tbl[5] = '{8'h00, 13'b11010_00000000, 1'b0, 1'b1, "00b"};
        v81    = '{8'h81, 13'b11010_10000001, 1'b0, 1'b0, "81"};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset outputs", {27'b0, stream_out, busy, sync_active, frame_done, data_ready}, 32'd0);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bad |= stream_out || !data_ready || busy || sync_active || frame_done;
        end
        check("idle 20 cycles", {31'b0, bad}, 32'd0);

        foreach (tbl[i]) send_frame(tbl[i]);

        // data_valid held high: FF then 00, one ready cycle per frame
        data_in    = 8'hFF;
        data_valid = 1'b1;
        s1 = '0; s2 = '0; rdy_cnt = 0; rdy_at = 0;
        for (int j = 1; j <= SP; j++) begin
            @(negedge clk);
            if (j == 1) data_in = 8'h00;
            if (j <= FL) s1 = {s1[30:0], stream_out};
            if (data_ready) begin
                rdy_cnt++;
                rdy_at = j;
            end
        end
        for (int j = 1; j <= FL; j++) begin
            @(negedge clk);
            if (j == 1) data_valid = 1'b0;
            s2 = {s2[30:0], stream_out};
        end
        check("b2b frame FF", s1, (PAR == 1) ? {18'b0, 13'b11010_11111111, 1'b0} : {19'b0, 13'b11010_11111111});
        check("b2b frame 00", s2, (PAR == 1) ? {18'b0, 13'b11010_00000000, 1'b0} : {19'b0, 13'b11010_00000000});
        check("b2b ready count", rdy_cnt, 32'd1);
        check("b2b spacing", rdy_at, SP);
        wait_idle("b2b");

        // Reset during the third payload bit of 3C
        data_in    = 8'h3C;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        seen = frame_done;
        repeat (7) begin
            @(negedge clk);
            seen |= frame_done;
        end
        check("3C third bit", {31'b0, stream_out}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset outputs", {27'b0, stream_out, busy, sync_active, frame_done, data_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready after rst", {30'b0, data_ready, busy}, 32'b10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen |= frame_done || stream_out;
        end
        check("aborted frame silent", {31'b0, seen}, 32'd0);
        send_frame(v81);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
